aes_inv_subbytes_seq: RTL and testbench
=======================================

# aes_inv_subbytes_seq

Sequences the AES InvSubBytes step over a 128-bit state by time-multiplexing a configurable number of registered inverse S-box lookup lanes. It sits in the decryption round datapath between InvShiftRows and AddRoundKey. It trades lookup area against latency: 16 lanes complete in one issue beat, 1 lane in sixteen. It uses valid/ready handshakes on both sides.

## Interface
- NUM_LANES, default 4: lookup lanes instantiated; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).
- BEATS, derived as 16/NUM_LANES: issue beats per state.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_state  in  128  input state; byte i = in_state[127-8i -: 8].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  substituted state, same byte order as in_state.
- busy  out  1  high in any state other than IDLE.
- fwd_mode  in  1  (only with AES_SUBBYTES_FWD_EN) 1 = forward S-box; sampled at input handshake.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- **IDLE:**
  - in_ready=1.
  - On in_valid: capture in_state into the source register, set beat counter k=0, go to ISSUE.
- **ISSUE:**
  - Lane j is addressed with source byte k*NUM_LANES+j.
  - Lane outputs from beat k-1 (available from cycle k onward) are written into result slots (k-1)*NUM_LANES+j.
  - k increments each cycle. Leave for DRAIN after k=BEATS-1.
- **DRAIN:**
  - Write the last beat's lane outputs into their result slots.
  - Set out_valid and go to HOLD.
- **HOLD:**
  - out_valid=1 and out_state stable until out_ready.
  - On out_ready with in_valid: accept the new state in the same cycle and go straight to ISSUE.
  - On out_ready without in_valid: go to IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is a combinational out_ready→in_ready path.
- in_state, and fwd_mode when present, are ignored outside accepting cycles. The source register is written only on an accept.
- Beat counter width: $clog2(BEATS), minimum 1 bit. When BEATS=1, ISSUE lasts one cycle.
- Reset values:
  - state=IDLE, k=0.
  - source and result registers 0, which makes out_state=0.
  - out_valid=0, busy=0, lane output registers 0.
- Reset mid-operation aborts the state immediately. No partial result is ever presented.
- With out_ready held low in HOLD, the block stalls indefinitely. Lanes are idle and the result is unchanged.

## Timing
- Each lane has one cycle of latency: the address is presented in cycle c and data is registered at the end of c.
- Input handshake at edge T → out_valid rises at edge T+BEATS+1.
  - NUM_LANES=16: 2 cycles.
  - NUM_LANES=4: 5 cycles.
  - NUM_LANES=1: 17 cycles.
- Sustained throughput with out_ready tied high: one state per BEATS+2 cycles, since the HOLD handshake cycle overlaps the next accept.
- out_valid and out_state are registered outputs. in_ready is combinational.

## Configuration
- AES_SUBBYTES_FWD_EN defined:
  - Adds the fwd_mode port and a forward S-box table per lane.
  - The lane output mux selects forward or inverse using the mode captured at accept.
  - Latency is unchanged.
- Undefined: no fwd_mode port, and lanes hold the inverse table only.

## Structure
- Shared package aes_pkg holds:
  - the state width and byte count constants;
  - the FSM state enum;
  - the legal-NUM_LANES check;
  - the byte-index helper function.
- Sub-module aes_inv_sbox_lane: one registered 256×8 lookup with rst_n clearing its output to 0. The forward table is present in it under AES_SUBBYTES_FWD_EN.
- Top level owns the FSM, beat counter, source/result registers and lane address/writeback muxing.

## Test plan
- NUM_LANES=4, in_state=0x0011_2233_4455_6677_8899_aabb_ccdd_eeff, out_ready=1 → out_valid 5 cycles after accept, out_state=0x52e3_9466_86ed_d302_97f9_62fe_27c9_997d.
- NUM_LANES=16 and NUM_LANES=1, in_state all bytes 0x63 → out_state all 0x00, latency 2 and 17 respectively.
- Back-pressure: out_ready low 10 cycles after out_valid → out_state and out_valid stable, in_ready=0. Raising out_ready with in_valid high → accept in the same cycle, busy never drops.
- rst_n asserted during ISSUE beat 2 → busy, out_valid and out_state go to 0 asynchronously. A fresh state after release produces the correct result with no stale bytes.
- Byte 0 = 0xff, byte 15 = 0x7c, others 0x00 → out byte 0 = 0x7d, byte 15 = 0x01, others 0x52.
- With AES_SUBBYTES_FWD_EN, fwd_mode=1, all bytes 0x53 → all bytes 0xed. fwd_mode toggling during ISSUE has no effect.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and index helpers for the AES InvSubBytes sequencer.
// Optional forward S-box support is controlled by AES_SUBBYTES_FWD_EN.
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    function automatic bit lanes_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    // State byte handled by a given lane in a given beat; byte 0 is the MSB byte.
    function automatic logic [3:0] byte_idx(input int beat, input int lanes, input int lane);
        return 4'(beat * lanes + lane);
    endfunction

endpackage

// File: rtl/aes_inv_sbox_lane.sv
// One registered 256x8 inverse S-box lookup; holds its output when not enabled.
// With AES_SUBBYTES_FWD_EN the forward table is added and selected by fwd.
module aes_inv_sbox_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef AES_SUBBYTES_FWD_EN
    input  logic       fwd,
`endif
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

`ifdef AES_SUBBYTES_FWD_EN
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 8'h00;
        end else if (en) begin
`ifdef AES_SUBBYTES_FWD_EN
            data <= fwd ? FWD_SBOX[addr] : INV_SBOX[addr];
`else
            data <= INV_SBOX[addr];
`endif
        end
    end

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// InvSubBytes sequencer: NUM_LANES registered S-box lanes swept over the state in BEATS beats.
// AES_SUBBYTES_FWD_EN adds the fwd_mode port and forward substitution.
module aes_inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef AES_SUBBYTES_FWD_EN
    input  logic               fwd_mode,
`endif
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int BEATS = NUM_BYTES / NUM_LANES;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!lanes_legal(NUM_LANES)) begin : g_bad_lanes
        $error("aes_inv_subbytes_seq: NUM_LANES must be 1, 2, 4, 8 or 16");
    end

    seq_state_t                  state;
    logic [KW-1:0]               k;
    logic [KW-1:0]               wb_beat;
    logic                        wb_vld;
    logic [0:NUM_BYTES-1][7:0]   src;
    logic [0:NUM_BYTES-1][7:0]   res;
    logic [7:0]                  lane_addr [NUM_LANES];
    logic [7:0]                  lane_data [NUM_LANES];
    logic                        lane_en;
    logic                        accept;
`ifdef AES_SUBBYTES_FWD_EN
    logic                        mode_q;
`endif

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign lane_en   = (state == ISSUE);
    assign out_state = res;

    always_comb begin
        for (int j = 0; j < NUM_LANES; j++) begin
            lane_addr[j] = src[byte_idx(32'(k), NUM_LANES, j)];
        end
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        aes_inv_sbox_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (lane_en),
`ifdef AES_SUBBYTES_FWD_EN
            .fwd   (mode_q),
`endif
            .addr  (lane_addr[j]),
            .data  (lane_data[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        k     <= '0;
                    end
                end
                ISSUE: begin
                    if (k == KW'(BEATS - 1)) begin
                        state <= DRAIN;
                        k     <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        k         <= '0;
                        state     <= in_valid ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane outputs trail their address by one cycle; wb_beat/wb_vld carry that beat forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src     <= '0;
            res     <= '0;
            wb_beat <= '0;
            wb_vld  <= 1'b0;
`ifdef AES_SUBBYTES_FWD_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                src <= in_state;
`ifdef AES_SUBBYTES_FWD_EN
                mode_q <= fwd_mode;
`endif
            end
            wb_vld  <= (state == ISSUE);
            wb_beat <= k;
            if (wb_vld) begin
                for (int j = 0; j < NUM_LANES; j++) begin
                    res[byte_idx(32'(wb_beat), NUM_LANES, j)] <= lane_data[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Directed bench for aes_inv_subbytes_seq at NUM_LANES = 4, 16 and 1.
// Forward-mode vectors are added when AES_SUBBYTES_FWD_EN is defined.
module tb_aes_inv_subbytes_seq;

    localparam logic [127:0] VEC_A   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] EXP_A   = 128'h52e39466_86edd302_97f962fe_27c9997d;
    localparam logic [127:0] VEC_63  = {16{8'h63}};
    localparam logic [127:0] VEC_BND = {8'hff, 112'h0, 8'h7c};
    localparam logic [127:0] EXP_BND = {8'h7d, {14{8'h52}}, 8'h01};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy      [3];
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];
`ifdef AES_SUBBYTES_FWD_EN
    logic         fwd_mode  [3];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: 4 lanes, instance 1: 16 lanes, instance 2: 1 lane.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_inv_subbytes_seq #(
            .NUM_LANES((g == 0) ? 4 : ((g == 1) ? 16 : 1))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
`ifdef AES_SUBBYTES_FWD_EN
            .fwd_mode  (fwd_mode[g]),
`endif
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Send one state to an idle instance with out_ready high; report latency and result.
    task automatic xfer(input int d, input logic [127:0] st, input bit fm,
                        output int lat, output logic [127:0] res);
        in_state[d] = st;
        in_valid[d] = 1'b1;
`ifdef AES_SUBBYTES_FWD_EN
        fwd_mode[d] = fm;
`else
        if (fm) $display("note: forward mode requested without AES_SUBBYTES_FWD_EN");
`endif
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_state[d] = '0;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
`ifdef AES_SUBBYTES_FWD_EN
            fwd_mode[d] = ~fwd_mode[d];
`endif
        end
        res = out_state[d];
        @(posedge clk); #1;
    endtask

    initial begin
        int           lat;
        logic [127:0] res;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_state[i]  = '0;
            out_ready[i] = 1'b1;
`ifdef AES_SUBBYTES_FWD_EN
            fwd_mode[i]  = 1'b0;
`endif
        end
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_busy",      128'(busy[0]),      128'd0);
        chk("rst_out_state", out_state[0],       128'd0);
        chk("rst_in_ready",  128'(in_ready[0]),  128'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, VEC_A, 1'b0, lat, res);
        chk("l4_lat", 128'(lat), 128'd5);
        chk("l4_vecA", res, EXP_A);

        xfer(1, VEC_63, 1'b0, lat, res);
        chk("l16_lat", 128'(lat), 128'd2);
        chk("l16_63", res, 128'd0);

        xfer(2, VEC_63, 1'b0, lat, res);
        chk("l1_lat", 128'(lat), 128'd17);
        chk("l1_63", res, 128'd0);

        xfer(2, VEC_BND, 1'b0, lat, res);
        chk("l1_bnd", res, EXP_BND);
        xfer(1, VEC_A, 1'b0, lat, res);
        chk("l16_vecA", res, EXP_A);

        // Abort during ISSUE beat 2, then verify a clean result afterwards.
        in_state[0] = VEC_BND;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",      128'(busy[0]),      128'd0);
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort_out_state", out_state[0],       128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, VEC_BND, 1'b0, lat, res);
        chk("post_abort_lat", 128'(lat), 128'd5);
        chk("post_abort_bnd", res, EXP_BND);

        // Back-pressure: hold the result, then accept in the release cycle.
        out_ready[0] = 1'b0;
        in_state[0]  = VEC_A;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", 128'(lat), 128'd5);
        in_state[0] = VEC_63;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_state", out_state[0], EXP_A);
            chk("bp_flags", {125'd0, out_valid[0], in_ready[0], busy[0]}, 128'b101);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        #1;
        chk("bp_in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("bp_reaccept", {126'd0, busy[0], out_valid[0]}, 128'b10);
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_next_lat", 128'(lat), 128'd5);
        chk("bp_next_res", out_state[0], 128'd0);
        @(posedge clk); #1;
        chk("bp_idle", 128'(busy[0]), 128'd0);

`ifdef AES_SUBBYTES_FWD_EN
        xfer(0, {16{8'h53}}, 1'b1, lat, res);
        chk("fwd_lat", 128'(lat), 128'd5);
        chk("fwd_53", res, {16{8'hed}});
        xfer(0, {16{8'h53}}, 1'b0, lat, res);
        chk("inv_53", res, {16{8'h50}});
        xfer(2, VEC_BND, 1'b1, lat, res);
        chk("l1_fwd_bnd", res, {8'h16, {14{8'h63}}, 8'h10});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
